stopwatch_bcd: RTL and testbench

//   MM:SS stopwatch downstream of the 1 Hz blink divider; consumes its o_clk_1Hz level.

---
 rtl/stopwatch_bcd.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS stopwatch counting seconds in BCD.
//   Rising edges of the divider's 1 Hz level are detected in the system clock domain and,
//   after TICKS_PER_SEC of them, one second is added. A start/stop/zero command FSM
//   (IDLE, RUN, PAUSE) gates counting. The counter wraps MAX_MIN:59 -> 00:00.
//
// Optional feature: define STOPWATCH_LAP_EN to add a lap latch (i_lap, o_lap_*).
//
// Ports:
//   i_clk_100MHz   system clock, all logic on the rising edge
//   i_clr          synchronous active-high reset
//   i_clk_1Hz      1 Hz square wave from the divider, same clock domain
//   i_start        one-cycle pulse: run
//   i_stop         one-cycle pulse: pause
//   i_zero         one-cycle pulse: clear count, return to IDLE
//   i_lap          (lap build) latch current digits while running
//   o_lap_valid    (lap build) lap latch holds a captured time
//   o_lap_*        (lap build) latched BCD digits
//   o_sec_ones     BCD 0-9
//   o_sec_tens     BCD 0-5
//   o_min_ones     BCD 0-9
//   o_min_tens     BCD 0-9
//   o_running      high while in RUN
//   o_rollover     one-cycle pulse on wrap to 00:00
module stopwatch_bcd #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned MAX_MIN       = 59
) (
   input  logic       i_clk_100MHz,
   input  logic       i_clr,
   input  logic       i_clk_1Hz,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_zero,
`ifdef STOPWATCH_LAP_EN
   input  logic       i_lap,
   output logic       o_lap_valid,
   output logic [3:0] o_lap_sec_ones,
   output logic [3:0] o_lap_sec_tens,
   output logic [3:0] o_lap_min_ones,
   output logic [3:0] o_lap_min_tens,
`endif
   output logic [3:0] o_sec_ones,
   output logic [3:0] o_sec_tens,
   output logic [3:0] o_min_ones,
   output logic [3:0] o_min_tens,
   output logic       o_running,
   output logic       o_rollover
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0] MaxMinTens = 4'(MAX_MIN / 10);
   localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN % 10);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e          state_q, state_d;
   logic            prev_q;
   logic [PW-1:0]   presc_q, presc_d;
   logic [3:0]      sec_ones_q, sec_ones_d;
   logic [3:0]      sec_tens_q, sec_tens_d;
   logic [3:0]      min_ones_q, min_ones_d;
   logic [3:0]      min_tens_q, min_tens_d;
   logic            rollover_q, rollover_d;
   logic            tick;

   assign tick = i_clk_1Hz & ~prev_q;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      rollover_d = 1'b0;
      if (i_zero) begin
         state_d    = StIdle;
         presc_d    = '0;
         sec_ones_d = '0;
         sec_tens_d = '0;
         min_ones_d = '0;
         min_tens_d = '0;
      end else if (i_stop) begin
         // stop beats a same-cycle start, so IDLE/PAUSE never leave here
         if (state_q == StRun) state_d = StPause;
      end else if (i_start && (state_q != StRun)) begin
         state_d = StRun;
      end else if ((state_q == StRun) && tick) begin
         if (presc_q == PrescLast) begin
            presc_d = '0;
            if (sec_ones_q != 4'd9) begin
               sec_ones_d = sec_ones_q + 4'd1;
            end else begin
               sec_ones_d = '0;
               if (sec_tens_q != 4'd5) begin
                  sec_tens_d = sec_tens_q + 4'd1;
               end else begin
                  sec_tens_d = '0;
                  if ((min_tens_q == MaxMinTens) && (min_ones_q == MaxMinOnes)) begin
                     min_ones_d = '0;
                     min_tens_d = '0;
                     rollover_d = 1'b1;
                  end else if (min_ones_q != 4'd9) begin
                     min_ones_d = min_ones_q + 4'd1;
                  end else begin
                     min_ones_d = '0;
                     min_tens_d = min_tens_q + 4'd1;
                  end
               end
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge i_clk_100MHz) begin
      if (i_clr) begin
         state_q    <= StIdle;
         prev_q     <= 1'b0;
         presc_q    <= '0;
         sec_ones_q <= '0;
         sec_tens_q <= '0;
         min_ones_q <= '0;
         min_tens_q <= '0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= i_clk_1Hz;
         presc_q    <= presc_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         rollover_q <= rollover_d;
      end
   end

   assign o_sec_ones = sec_ones_q;
   assign o_sec_tens = sec_tens_q;
   assign o_min_ones = min_ones_q;
   assign o_min_tens = min_tens_q;
   assign o_running  = (state_q == StRun);
   assign o_rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
   logic        lap_valid_q;
   logic [15:0] lap_q;

   // Lap captures the displayed (pre-increment) digits of the cycle i_lap is seen.
   always_ff @(posedge i_clk_100MHz) begin
      if (i_clr || i_zero) begin
         lap_valid_q <= 1'b0;
         lap_q       <= '0;
      end else if (i_lap && (state_q == StRun)) begin
         lap_valid_q <= 1'b1;
         lap_q       <= {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
      end
   end

   assign o_lap_valid    = lap_valid_q;
   assign o_lap_min_tens = lap_q[15:12];
   assign o_lap_min_ones = lap_q[11:8];
   assign o_lap_sec_tens = lap_q[7:4];
   assign o_lap_sec_ones = lap_q[3:0];
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed bench for stopwatch_bcd. Two instances share the stimulus:
// u_dut (TICKS_PER_SEC=1) and u_dut3 (TICKS_PER_SEC=3). Expected values are pushed into a
// queue by the stimulus; a monitor pops and compares them on the falling clock edge.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic clr, clk1hz, start, stop, zero;

  logic [3:0] so, st, mo, mt;
  logic       running, rollover;
  logic [3:0] so3, st3, mo3, mt3;
  logic       running3, rollover3;

`ifdef STOPWATCH_LAP_EN
  logic       lap;
  logic       lap_valid, lap_valid3;
  logic [3:0] lso, lst, lmo, lmt, lso3, lst3, lmo3, lmt3;
`endif

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICKS_PER_SEC(1), .MAX_MIN(59)) u_dut (
    .i_clk_100MHz (clk),
    .i_clr        (clr),
    .i_clk_1Hz    (clk1hz),
    .i_start      (start),
    .i_stop       (stop),
    .i_zero       (zero),
`ifdef STOPWATCH_LAP_EN
    .i_lap          (lap),
    .o_lap_valid    (lap_valid),
    .o_lap_sec_ones (lso),
    .o_lap_sec_tens (lst),
    .o_lap_min_ones (lmo),
    .o_lap_min_tens (lmt),
`endif
    .o_sec_ones   (so),
    .o_sec_tens   (st),
    .o_min_ones   (mo),
    .o_min_tens   (mt),
    .o_running    (running),
    .o_rollover   (rollover)
  );

  stopwatch_bcd #(.TICKS_PER_SEC(3), .MAX_MIN(59)) u_dut3 (
    .i_clk_100MHz (clk),
    .i_clr        (clr),
    .i_clk_1Hz    (clk1hz),
    .i_start      (start),
    .i_stop       (stop),
    .i_zero       (zero),
`ifdef STOPWATCH_LAP_EN
    .i_lap          (lap),
    .o_lap_valid    (lap_valid3),
    .o_lap_sec_ones (lso3),
    .o_lap_sec_tens (lst3),
    .o_lap_min_ones (lmo3),
    .o_lap_min_tens (lmt3),
`endif
    .o_sec_ones   (so3),
    .o_sec_tens   (st3),
    .o_min_ones   (mo3),
    .o_min_tens   (mt3),
    .o_running    (running3),
    .o_rollover   (rollover3)
  );

  // which: 0 = u_dut digits, 1 = u_dut3 digits, 2 = u_dut lap latch (run field = valid)
  typedef struct {
    string       name;
    int          which;
    logic [15:0] val;
    logic        run;
    logic        roll;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [15:0] a_val;
      logic        a_run, a_roll;
      e      = q.pop_front();
      a_val  = {mt, mo, st, so};
      a_run  = running;
      a_roll = rollover;
      if (e.which == 1) begin
        a_val  = {mt3, mo3, st3, so3};
        a_run  = running3;
        a_roll = rollover3;
      end
`ifdef STOPWATCH_LAP_EN
      if (e.which == 2) begin
        a_val  = {lmt, lmo, lst, lso};
        a_run  = lap_valid;
        a_roll = 1'b0;
      end
`endif
      n_cmp++;
      if (a_val !== e.val || a_run !== e.run || a_roll !== e.roll) begin
        n_fail++;
        $display("FAIL %s: got %h run/valid=%b roll=%b, want %h run/valid=%b roll=%b",
                 e.name, a_val, a_run, a_roll, e.val, e.run, e.roll);
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL timeout: stimulus did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input int w, input logic [15:0] v, input logic r,
                          input logic ro);
    exp_t e;
    e.name  = n;
    e.which = w;
    e.val   = v;
    e.run   = r;
    e.roll  = ro;
    q.push_back(e);
  endtask

  // One 1 Hz period: high 2 clocks, low 2 clocks.
  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      clk1hz = 1'b1;
      step();
      step();
      clk1hz = 1'b0;
      step();
      step();
    end
  endtask

  task automatic cmd(input logic s, input logic p, input logic z);
    start = s;
    stop  = p;
    zero  = z;
    step();
    start = 1'b0;
    stop  = 1'b0;
    zero  = 1'b0;
  endtask

  initial begin
    clr    = 1'b1;
    clk1hz = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    zero   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap    = 1'b0;
`endif
    step();
    step();
    n_cmp++;
    if ({mt, mo, st, so} !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0 ||
        {mt3, mo3, st3, so3} !== 16'h0000 || running3 !== 1'b0 || rollover3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_direct: got %h/%b/%b and %h/%b/%b, want all zero",
               {mt, mo, st, so}, running, rollover, {mt3, mo3, st3, so3}, running3,
               rollover3);
    end
    expect_v("reset", 0, 16'h0000, 1'b0, 1'b0);
    expect_v("reset_tps3", 1, 16'h0000, 1'b0, 1'b0);
    clr = 1'b0;
    step();

    // Basic counting, both prescaler settings
    cmd(1'b1, 1'b0, 1'b0);
    expect_v("start_run", 0, 16'h0000, 1'b1, 1'b0);
    edges(5);
    expect_v("five_edges", 0, 16'h0005, 1'b1, 1'b0);
    edges(4);
    expect_v("nine_edges", 0, 16'h0009, 1'b1, 1'b0);
    expect_v("tps3_nine_edges", 1, 16'h0003, 1'b1, 1'b0);

    // Zero while running, then pause/resume
    cmd(1'b0, 1'b0, 1'b1);
    expect_v("zero_in_run", 0, 16'h0000, 1'b0, 1'b0);
    expect_v("zero_in_run_tps3", 1, 16'h0000, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    edges(3);
    expect_v("run_three", 0, 16'h0003, 1'b1, 1'b0);
    cmd(1'b0, 1'b1, 1'b0);
    edges(4);
    expect_v("paused_hold", 0, 16'h0003, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    edges(2);
    expect_v("resume_two", 0, 16'h0005, 1'b1, 1'b0);

    // Start and stop together in PAUSE: stays paused, ticks ignored
    cmd(1'b0, 1'b1, 1'b0);
    cmd(1'b1, 1'b1, 1'b0);
    expect_v("start_stop_pause", 0, 16'h0005, 1'b0, 1'b0);
    edges(1);
    expect_v("pause_ignores_tick", 0, 16'h0005, 1'b0, 1'b0);

    // Edge in the same cycle as stop is dropped
    cmd(1'b1, 1'b0, 1'b0);
    clk1hz = 1'b1;
    stop   = 1'b1;
    step();
    stop   = 1'b0;
    step();
    clk1hz = 1'b0;
    step();
    step();
    expect_v("edge_with_stop", 0, 16'h0005, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    edges(1);
    expect_v("resume_after_drop", 0, 16'h0006, 1'b1, 1'b0);

    // Run to 12:34, then clear with a same-cycle edge
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    edges(754);
    expect_v("at_12_34", 0, 16'h1234, 1'b1, 1'b0);
    clr    = 1'b1;
    clk1hz = 1'b1;
    step();
    clr    = 1'b0;
    expect_v("clr_with_edge", 0, 16'h0000, 1'b0, 1'b0);
    expect_v("clr_with_edge_tps3", 1, 16'h0000, 1'b0, 1'b0);
    step();
    expect_v("idle_hold", 0, 16'h0000, 1'b0, 1'b0);
    clk1hz = 1'b0;
    step();
    cmd(1'b1, 1'b0, 1'b0);
    edges(1);
    expect_v("count_after_clr", 0, 16'h0001, 1'b1, 1'b0);

    // Full wrap at 59:59
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    edges(3598);
    expect_v("at_59_58", 0, 16'h5958, 1'b1, 1'b0);
    edges(1);
    expect_v("at_59_59", 0, 16'h5959, 1'b1, 1'b0);
    clk1hz = 1'b1;
    step();
    expect_v("rollover_pulse", 0, 16'h0000, 1'b1, 1'b1);
    step();
    expect_v("rollover_one_cycle", 0, 16'h0000, 1'b1, 1'b0);
    clk1hz = 1'b0;
    step();
    step();
    edges(1);
    expect_v("after_wrap", 0, 16'h0001, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_EN
    cmd(1'b0, 1'b0, 1'b1);
    lap = 1'b1;
    step();
    lap = 1'b0;
    expect_v("lap_idle_ignored", 2, 16'h0000, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    edges(7);
    lap = 1'b1;
    step();
    lap = 1'b0;
    expect_v("lap_capture", 2, 16'h0007, 1'b1, 1'b0);
    edges(3);
    expect_v("lap_main", 0, 16'h0010, 1'b1, 1'b0);
    expect_v("lap_held", 2, 16'h0007, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1);
    expect_v("lap_zeroed", 2, 16'h0000, 1'b0, 1'b0);
`endif

    step();
    step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
